chunked_seq_adder: RTL
======================

Name: chunked_seq_adder

Overview:
Multi-cycle parametrised adder/subtractor, successor to the fixed 4-bit ripple-carry adder. Operands are WIDTH bits wide. One CHUNK-bit ripple slice is processed per clock, and the carry is registered between slices. Valid/ready handshakes on input and output let it sit between datapath stages where area matters more than latency.

Parameters:
- WIDTH, 16: operand and sum width in bits. Must be a multiple of CHUNK.
- CHUNK, 4: bits added per cycle. Must be ≥1 and ≤ WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add only)
- op_sub  in  1  0 = A+B+cin; 1 = A−B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out; for subtract, 1 = no borrow (A ≥ B unsigned)
- busy  out  1  high in BUSY or DONE

Interface rule: one clock (clk); reset rst_n is asynchronous, active-low.

Behaviour:
- N = WIDTH/CHUNK slices; an internal chunk counter of ceil(log2(N+1)) bits.
- States: IDLE, BUSY, DONE.
- Reset (async assert, any state): state = IDLE, in_ready = 1, out_valid = 0, sum = 0, cout = 0, busy = 0; counter, operand and carry registers are zeroed. Any in-flight operation is discarded with no output.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at edge t: latch a, and b or ~b when op_sub; carry = op_sub ? 1 : cin; counter = 0; go to BUSY.
- BUSY:
  - in_ready = 0; in_valid is ignored.
  - Each edge adds the low CHUNK bits of the operand shift registers plus the carry.
  - The slice sum shifts into sum from the MSB end; the carry register is updated; operands shift right by CHUNK; counter increments.
  - After the edge where counter reaches N−1 (edge t+N): go to DONE, cout = final carry, out_valid = 1.
- DONE:
  - sum and cout are held stable while out_valid && !out_ready.
  - On out_ready: out_valid = 0, go to IDLE.
  - A new operand cannot be accepted in the same cycle.
- Timing:
  - Latency from input handshake to out_valid is N cycles.
  - Throughput is one result per N+2 cycles with out_ready tied high.
- Arithmetic: modulo 2^WIDTH; no saturation; cin is ignored when op_sub = 1.
- Edge cases:
  - CHUNK = WIDTH gives 1-cycle latency.
  - CHUNK = 1 gives a bit-serial adder.
  - Inputs changing after acceptance have no effect.

Optional Feature:
- Macro: CHUNKED_ADDER_OVF_EN.
- When defined:
  - Adds output ovf (1 bit), signed two's-complement overflow.
  - ovf = carry into MSB XOR carry out of MSB, captured with cout.
  - Reset value 0; held in DONE; valid only with out_valid.
- When undefined: no ovf port and no associated logic.

Decomposition:
- Package chunked_adder_pkg holds:
  - the state enum (IDLE/BUSY/DONE);
  - the localparam function computing N and the counter width;
  - the elaboration-time parameter check (WIDTH % CHUNK == 0).
- Sub-module chunk_rca is combinational, CHUNK bits wide (sum, cout, a, b, cin). It is built as a generate chain of full-adder instances and is instantiated once per design.

Test Plan:
All scenarios use WIDTH = 16, CHUNK = 4.
1. Basic add: a=0x1234, b=0x1111, cin=0, add → sum 0x2345, cout 0; out_valid asserted exactly 4 cycles after the input handshake.
2. Full carry ripple: a=0xFFFF, b=0x0001, cin=0 → sum 0x0000, cout 1. Repeat with cin=1, b=0x0000 → same result.
3. Subtract:
   - 0x0005−0x0007 → sum 0xFFFE, cout 0.
   - 0x0007−0x0005 → sum 0x0002, cout 1.
   - cin=1 has no effect on either.
4. Backpressure and busy input:
   - Hold out_ready = 0 for 3 cycles → sum and cout stable, out_valid stays 1.
   - Pulse in_valid with new operands during BUSY → ignored; in_ready = 0 throughout.
5. Reset mid-operation: assert rst_n = 0 asynchronously two cycles into BUSY → all outputs at reset values immediately; after release, a fresh operation 0x00FF + 0x0001 → sum 0x0100.
6. With CHUNKED_ADDER_OVF_EN defined:
   - 0x7FFF + 0x0001 → ovf 1, sum 0x8000.
   - 0x8000 − 0x0001 → ovf 1, sum 0x7FFF.
   - 0x0001 + 0x0001 → ovf 0.

Source files
------------

// File: rtl/chunked_adder_pkg.sv
// chunked_adder_pkg: shared state encoding, sizing helpers and config check for chunked_seq_adder.
package chunked_adder_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int num_chunks(input int w, input int c);
    return w / c;
  endfunction
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic bit cfg_ok(input int w, input int c);
    return c >= 1 && c <= w && w % c == 0;
  endfunction
endpackage

// File: rtl/chunk_rca.sv
// chunk_rca: combinational CHUNK-bit ripple-carry slice built from a chain of full adders.
module full_adder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_rca #(
  parameter int CHUNK = 4
) (
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin
);
  logic [CHUNK:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (.sum(sum[i]), .cout(c[i+1]), .a(a[i]), .b(b[i]), .cin(c[i]));
  end
  assign cout = c[CHUNK];
endmodule

// File: rtl/chunked_seq_adder.sv
// chunked_seq_adder: multi-cycle add/subtract, one CHUNK-bit slice per clock with valid/ready handshakes.
// Define CHUNKED_ADDER_OVF_EN to add the signed-overflow output ovf.
module chunked_seq_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CHUNKED_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);
  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int CW = cnt_width(N);
  if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("chunked_seq_adder: WIDTH must be a positive multiple of CHUNK");
  end
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa, opb;
  logic             carry;
  logic [CHUNK-1:0] s_sum;
  logic             s_cout;
  chunk_rca #(.CHUNK(CHUNK)) u_rca (
    .sum(s_sum), .cout(s_cout), .a(opa[CHUNK-1:0]), .b(opb[CHUNK-1:0]), .cin(carry)
  );
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
`ifdef CHUNKED_ADDER_OVF_EN
  // Carry into the MSB is recovered from the top slice's sum bit and its operand bits.
  logic msb_c;
  assign msb_c = s_sum[CHUNK-1] ^ opa[CHUNK-1] ^ opb[CHUNK-1];
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opa   <= a;
          opb   <= op_sub ? ~b : b;
          carry <= op_sub | cin;
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          // Slice results enter at the MSB so the full sum lines up after N shifts.
          sum   <= (sum >> CHUNK) | (WIDTH'(s_sum) << (WIDTH - CHUNK));
          opa   <= opa >> CHUNK;
          opb   <= opb >> CHUNK;
          carry <= s_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            cout  <= s_cout;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf   <= msb_c ^ s_cout;
`endif
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
